// File: rtl/deser_queue_ctrl.sv
// deser_queue_ctrl: moves deserializer bytes into an 8-entry byte queue and serves consumer pops
// Ports:
//   clock, reset       system clock; asynchronous active-low reset
//   deser_valid/data   assembled byte from the deserializer (one-cycle pulse)
//   status_out         flow control to the deserializer, with hysteresis
//   q_enq/q_wdata      queue write strobe and data
//   q_len              queue occupancy
//   q_deq/q_rdata      queue read strobe and registered head data
//   rd_req             consumer pop request (one-cycle pulse)
//   rd_valid/data/err  pop response; rd_err flags a pop on an empty queue
//   drop_cnt           saturating count of dropped bytes
//   busy               FSM active or a request pending
module deser_queue_ctrl #(
    parameter int DEPTH   = 8,
    parameter int LEN_W   = 4,
    parameter int HI_MARK = 7,
    parameter int LO_MARK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             deser_valid,
    input  logic [7:0]       deser_data,
    output logic             status_out,
    output logic             q_enq,
    output logic [7:0]       q_wdata,
    input  logic [LEN_W-1:0] q_len,
    output logic             q_deq,
    input  logic [7:0]       q_rdata,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_err,
    output logic [7:0]       drop_cnt,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, POP_CAP} state_t;
    state_t state, state_n;
    logic push_pend, pop_pend, push_clr, pop_clr, cap, err_rsp, accept;
    logic [7:0] hold;
    logic [LEN_W:0] occ;
    // a byte already held counts as occupancy so the deserializer is throttled early
    assign occ = {1'b0, q_len} + {{LEN_W{1'b0}}, push_pend};
    assign accept = deser_valid & ~push_pend & (occ < (LEN_W+1)'(DEPTH));
    assign q_enq = (state == PUSH);
    assign q_deq = (state == POP);
    assign q_wdata = q_enq ? hold : 8'h00;
    assign busy = (state != IDLE) | push_pend | pop_pend;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        push_clr = 1'b0;
        pop_clr = 1'b0;
        cap = 1'b0;
        err_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (push_pend) state_n = PUSH;
                else if (pop_pend && q_len != '0) state_n = POP;
                else if (pop_pend) begin
                    err_rsp = 1'b1;
                    pop_clr = 1'b1;
                end
            end
            PUSH: begin
                push_clr = 1'b1;
                state_n = IDLE;
            end
            POP: state_n = POP_WAIT;
            // queue read data is registered, so give it one cycle to settle
            POP_WAIT: state_n = POP_CAP;
            POP_CAP: begin
                cap = 1'b1;
                pop_clr = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            push_pend <= 1'b0;
            pop_pend <= 1'b0;
            hold <= 8'h00;
            drop_cnt <= 8'h00;
            status_out <= 1'b1;
            rd_valid <= 1'b0;
            rd_err <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            push_pend <= push_pend ? ~push_clr : accept;
            // a request arriving while one is pending is ignored
            pop_pend <= pop_pend ? ~pop_clr : rd_req;
            if (accept) hold <= deser_data;
            if (deser_valid && !accept && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            status_out <= (occ >= (LEN_W+1)'(HI_MARK)) ? 1'b0 :
                          (occ <= (LEN_W+1)'(LO_MARK)) ? 1'b1 : status_out;
            rd_valid <= cap | err_rsp;
            rd_err <= err_rsp;
            if (cap) rd_data <= q_rdata;
        end
    end
endmodule

// File: tb/tb_deser_queue_ctrl.sv
// tb_deser_queue_ctrl: directed self-checking bench with a behavioural 8-entry queue
module tb_deser_queue_ctrl;
    logic clock = 1'b0;
    logic reset;
    logic deser_valid, rd_req;
    logic [7:0] deser_data;
    logic status_out, q_enq, q_deq, rd_valid, rd_err, busy;
    logic [7:0] q_wdata, q_rdata, rd_data, drop_cnt;
    logic [3:0] q_len;
    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int full_enq = 0;
    logic [7:0] mem [8];
    logic [2:0] wp = '0, rp = '0;
    logic [3:0] cnt = '0;
    logic [7:0] rq = '0;

    deser_queue_ctrl dut (
        .clock(clock), .reset(reset), .deser_valid(deser_valid), .deser_data(deser_data),
        .status_out(status_out), .q_enq(q_enq), .q_wdata(q_wdata), .q_len(q_len),
        .q_deq(q_deq), .q_rdata(q_rdata), .rd_req(rd_req), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clock = ~clock;

    // queue stub: registered read data appears the cycle after q_deq
    assign q_len = cnt;
    assign q_rdata = rq;
    always @(posedge clock) begin
        if (q_enq && cnt != 4'd8) begin
            mem[wp] <= q_wdata;
            wp <= wp + 3'd1;
        end
        if (q_deq && cnt != 4'd0) begin
            rq <= mem[rp];
            rp <= rp + 3'd1;
        end
        cnt <= cnt + 4'((q_enq && cnt != 4'd8) ? 1 : 0) - 4'((q_deq && cnt != 4'd0) ? 1 : 0);
    end

    always @(negedge clock) begin
        if (q_enq && q_deq) overlap++;
        if (q_enq && q_len == 4'd8) full_enq++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        deser_valid = 1'b1;
        deser_data = d;
        step();
        deser_valid = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic pop_exp(input string tag, input logic [7:0] d, input logic e, input int lat_exp);
        int lat;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        lat = 1;
        while (!rd_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, lat_exp);
        check({tag, "_data"}, rd_data, d);
        check({tag, "_err"}, rd_err, e);
        step();
        check({tag, "_pulse"}, rd_valid, 0);
    endtask

    initial begin
        int n, enq_at, deq_at;
        reset = 1'b0;
        deser_valid = 1'b0;
        rd_req = 1'b0;
        deser_data = 8'h00;
        step();
        step();
        check("rst_status", status_out, 1);
        check("rst_drop", drop_cnt, 0);
        check("rst_strobes", {q_enq, q_deq, rd_valid, rd_err}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wdata", q_wdata, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        step();
        check("post_rst_status", status_out, 1);

        deser_valid = 1'b1;
        deser_data = 8'h80;
        step();
        deser_valid = 1'b0;
        check("push_c1", q_enq, 0);
        step();
        check("push_c2", q_enq, 1);
        check("push_wdata", q_wdata, 8'h80);
        step();
        check("push_c3", q_enq, 0);
        step();

        for (int i = 1; i <= 5; i++) push_byte(8'h80 + 8'(i));
        check("hyst_occ6", status_out, 1);
        push_byte(8'h86);
        check("hyst_occ7", status_out, 0);
        push_byte(8'h87);
        check("hyst_occ8", status_out, 0);
        check("idle_busy", busy, 0);

        deser_valid = 1'b1;
        deser_data = 8'h88;
        step();
        deser_valid = 1'b0;
        step();
        check("ovf_drop1", drop_cnt, 1);
        check("ovf_no_enq", q_enq, 0);
        deser_valid = 1'b1;
        repeat (300) step();
        deser_valid = 1'b0;
        step();
        check("ovf_sat", drop_cnt, 255);

        for (int i = 0; i < 8; i++) begin
            pop_exp($sformatf("pop%0d", i), 8'h80 + 8'(i), 1'b0, 5);
            if (i < 3) check($sformatf("pop%0d_status", i), status_out, 0);
            else if (i == 3) check("pop3_status", status_out, 1);
        end
        pop_exp("pop_empty", 8'h87, 1'b1, 2);

        deser_valid = 1'b1;
        rd_req = 1'b1;
        deser_data = 8'hA5;
        step();
        deser_valid = 1'b0;
        rd_req = 1'b0;
        n = 1;
        enq_at = 0;
        deq_at = 0;
        while (!rd_valid && n < 15) begin
            if (q_enq && enq_at == 0) enq_at = n;
            if (q_deq && deq_at == 0) deq_at = n;
            step();
            n++;
        end
        check("col_enq_at", enq_at, 2);
        check("col_deq_at", deq_at, 4);
        check("col_rd_at", n, 7);
        check("col_data", rd_data, 8'hA5);
        check("col_err", rd_err, 0);
        step();

        push_byte(8'h5A);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        check("mid_pop_deq", q_deq, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_deq", q_deq, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_status", status_out, 1);
        step();
        reset = 1'b1;
        step();

        check("no_overlap", overlap, 0);
        check("no_enq_full", full_enq, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
